mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/arm_pkg.sv | 18 +
 rtl/wb_mux.sv | 14 +
 rtl/mem_wb_stage.sv | 102 ++++++++++
 tb/tb_mem_wb_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared widths, stage FSM encoding and a saturating-increment helper for the MEM/WB slice.
// Pure declarations; no logic or timing of its own.
package arm_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 4;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } stage_state_t;

   // Event counters stick at all-ones rather than wrapping back to zero.
   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (&v) ? v : v + DATA_W'(1);
   endfunction

endpackage

// File: rtl/wb_mux.sv
// Writeback data select: load data when the retiring op was a load, ALU result otherwise.
// Zero latency (pure combinational); no flow control of its own.
import arm_pkg::*;

module wb_mux (
   input  logic              mem_r_en,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] wb_value
);

   assign wb_value = mem_r_en ? mem_data : alu_res;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a RUN/WAIT memory-handshake FSM, stall/retire counters.
// One-cycle latency to the register file; an incomplete memory access freezes upstream and inserts bubbles.
import arm_pkg::*;

module mem_wb_stage (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WB_EN_in,
   input  logic                  MEM_R_EN_in,
   input  logic                  MEM_W_EN_in,
   input  logic [DATA_W-1:0]     ALU_Res_in,
   input  logic [DATA_W-1:0]     Mem_out,
   input  logic [REG_ADDR_W-1:0] WB_Dest_in,
   input  logic                  mem_ready,
   output logic                  WB_EN,
   output logic [REG_ADDR_W-1:0] WB_Dest,
   output logic [DATA_W-1:0]     WB_Value,
   output logic                  freeze,
   output logic                  busy,
   output logic [DATA_W-1:0]     stall_count,
   output logic [DATA_W-1:0]     retire_count
);

   logic                  access;
   logic                  slot_vld;
   stage_state_t          state_q;
   stage_state_t          state_d;

   logic                  wb_en_q;
   logic                  mem_r_en_q;
   logic [DATA_W-1:0]     alu_res_q;
   logic [DATA_W-1:0]     mem_dat_q;
   logic [REG_ADDR_W-1:0] wb_dest_q;
   logic [DATA_W-1:0]     stall_cnt_q;
   logic [DATA_W-1:0]     retire_cnt_q;

   assign access   = MEM_R_EN_in | MEM_W_EN_in;
   assign freeze   = access & ~mem_ready;
   assign slot_vld = WB_EN_in | access;

   // Next-state logic; a same-cycle access+ready never visits WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (access && !mem_ready) state_d = ST_WAIT;
         ST_WAIT: if (mem_ready)            state_d = ST_RUN;
         default:                           state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Frozen edges load a bubble: only the write enable drops, data fields keep their values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         alu_res_q  <= '0;
         mem_dat_q  <= '0;
         wb_dest_q  <= '0;
      end else if (freeze) begin
         wb_en_q    <= 1'b0;
      end else begin
         wb_en_q    <= WB_EN_in;
         mem_r_en_q <= MEM_R_EN_in;
         alu_res_q  <= ALU_Res_in;
         mem_dat_q  <= Mem_out;
         wb_dest_q  <= WB_Dest_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else if (freeze) begin
         stall_cnt_q  <= sat_inc(stall_cnt_q);
      end else if (slot_vld) begin
         retire_cnt_q <= sat_inc(retire_cnt_q);
      end
   end

   wb_mux u_wb_mux (
      .mem_r_en (mem_r_en_q),
      .alu_res  (alu_res_q),
      .mem_data (mem_dat_q),
      .wb_value (WB_Value)
   );

   assign WB_EN        = wb_en_q;
   assign WB_Dest      = wb_dest_q;
   assign busy         = (state_q == ST_WAIT);
   assign stall_count  = stall_cnt_q;
   assign retire_count = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a cycle-level behavioural model.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, mem_ready;
   logic [31:0] ALU_Res_in, Mem_out;
   logic [3:0]  WB_Dest_in;
   logic        WB_EN, freeze, busy;
   logic [3:0]  WB_Dest;
   logic [31:0] WB_Value, stall_count, retire_count;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic        m_wb_en;
   logic [3:0]  m_dest;
   logic [31:0] m_value;
   logic        m_waiting;
   logic [31:0] m_stall, m_retire;

   mem_wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .WB_EN_in     (WB_EN_in),
      .MEM_R_EN_in  (MEM_R_EN_in),
      .MEM_W_EN_in  (MEM_W_EN_in),
      .ALU_Res_in   (ALU_Res_in),
      .Mem_out      (Mem_out),
      .WB_Dest_in   (WB_Dest_in),
      .mem_ready    (mem_ready),
      .WB_EN        (WB_EN),
      .WB_Dest      (WB_Dest),
      .WB_Value     (WB_Value),
      .freeze       (freeze),
      .busy         (busy),
      .stall_count  (stall_count),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_wb_en   = 1'b0;
      m_dest    = '0;
      m_value   = '0;
      m_waiting = 1'b0;
      m_stall   = '0;
      m_retire  = '0;
   endtask

   task automatic check_outputs(input string ph);
      chk({ph, ".WB_EN"},        {31'd0, WB_EN},   {31'd0, m_wb_en});
      chk({ph, ".WB_Dest"},      {28'd0, WB_Dest}, {28'd0, m_dest});
      chk({ph, ".WB_Value"},     WB_Value,         m_value);
      chk({ph, ".busy"},         {31'd0, busy},    {31'd0, m_waiting});
      chk({ph, ".stall_count"},  stall_count,      m_stall);
      chk({ph, ".retire_count"}, retire_count,     m_retire);
   endtask

   // One clock: drive at negedge, check freeze, advance model at posedge, check outputs just after.
   task automatic step(input string ph, input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [3:0] dst, input logic rdy);
      bit acc;
      @(negedge clk);
      WB_EN_in = wb; MEM_R_EN_in = rd; MEM_W_EN_in = wr;
      ALU_Res_in = alu; Mem_out = mem; WB_Dest_in = dst; mem_ready = rdy;
      acc = rd | wr;
      #1 chk({ph, ".freeze"}, {31'd0, freeze}, {31'd0, acc && !rdy});
      @(posedge clk);
      if (acc && !rdy) begin
         m_wb_en = 1'b0;
         if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      end else begin
         m_wb_en = wb;
         m_dest  = dst;
         m_value = rd ? mem : alu;
         if ((wb || acc) && m_retire != 32'hFFFF_FFFF) m_retire = m_retire + 1;
      end
      if (rdy)      m_waiting = 1'b0;
      else if (acc) m_waiting = 1'b1;
      #1 check_outputs(ph);
   endtask

   task automatic idle(input string ph);
      step(ph, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
      ALU_Res_in = 0; Mem_out = 0; WB_Dest_in = 0; mem_ready = 0;
      model_reset();
      #12;
      check_outputs("reset");
      chk("reset.freeze", {31'd0, freeze}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ALU op
      step("alu", 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hAAAA_AAAA, 4'd3, 1'b0);
      chk("alu.value_const", WB_Value, 32'h10);
      chk("alu.retire_const", retire_count, 32'd1);

      // Load completing in the same cycle
      step("ld0", 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'd5, 1'b1);
      chk("ld0.value_const", WB_Value, 32'hDEAD_BEEF);
      chk("ld0.stall_const", stall_count, 32'd0);

      // Load with three wait cycles
      for (int i = 0; i < 3; i++)
         step("ld3w", 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'd7, 1'b0);
      step("ld3r", 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, 4'd7, 1'b1);
      chk("ld3.stall_const", stall_count, 32'd3);
      chk("ld3.retire_const", retire_count, 32'd3);
      chk("ld3.value_const", WB_Value, 32'hCAFE_F00D);
      idle("ld3.after");

      // Store with two wait cycles
      for (int i = 0; i < 2; i++)
         step("stw", 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 4'd9, 1'b0);
      step("str", 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 4'd9, 1'b1);
      chk("st.stall_const", stall_count, 32'd5);
      chk("st.retire_const", retire_count, 32'd4);

      // mem_ready without access is ignored
      step("rdy_noacc", 1'b0, 1'b0, 1'b0, 32'h5, 32'h6, 4'd1, 1'b1);

      // Reset while waiting on a load
      step("rstw", 1'b1, 1'b1, 1'b0, 32'h4000, 32'h7777_7777, 4'd11, 1'b0);
      step("rstw", 1'b1, 1'b1, 1'b0, 32'h4000, 32'h7777_7777, 4'd11, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs("rst_mid");
      chk("rst_mid.freeze", {31'd0, freeze}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      WB_EN_in = 0; MEM_R_EN_in = 0; mem_ready = 0;
      idle("post_rst");
      idle("post_rst2");

      // Saturation of stall_count
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFD;
      #1 release dut.stall_cnt_q;
      m_stall = 32'hFFFF_FFFD;
      for (int i = 0; i < 5; i++)
         step("sat", 1'b1, 1'b1, 1'b0, 32'h8, 32'h9, 4'd2, 1'b0);
      chk("sat.stall_const", stall_count, 32'hFFFF_FFFF);
      step("sat.rel", 1'b1, 1'b1, 1'b0, 32'h8, 32'h9, 4'd2, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [1:0] kind;
         kind = 2'($urandom_range(0, 3));
         step("rnd", ($urandom_range(0, 3) != 0) && (kind != 2'd2),
              kind == 2'd1, kind == 2'd2,
              $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 1) == 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
